// File: rtl/mem_stage.sv
// MEM stage: issues LOAD/STORE as req/ack bus transactions and forwards results to WB.
// Define MEM_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles and raise a sticky mem_err.

`ifndef EXEC
`define EXEC 1'b1
`endif
`ifndef LOAD
`define LOAD 5'b10001
`endif

module mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        state,
    input  logic [15:0] mem_ir,
    input  logic [15:0] reg_C,
    input  logic        dw,
    input  logic [15:0] smdr1,
    output logic        d_req,
    output logic        d_we,
    output logic [15:0] d_addr,
    output logic [15:0] d_wdata,
    input  logic        d_ack,
    input  logic [15:0] d_rdata,
    output logic [15:0] wb_ir,
    output logic [15:0] reg_C1,
    output logic        mem_busy,
    output logic        mem_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } fsm_t;

    fsm_t        r_fsm, w_fsm_nx;
    logic        r_req, w_req_nx;
    logic        r_we, w_we_nx;
    logic [15:0] r_addr, w_addr_nx;
    logic [15:0] r_wdata, w_wdata_nx;
    logic [15:0] r_wb_ir, w_wb_ir_nx;
    logic [15:0] r_c1, w_c1_nx;
    logic        r_busy, w_busy_nx;
    logic [15:0] r_ir, w_ir_nx;
    logic        w_mem_op;

    assign w_mem_op = dw | (mem_ir[15:11] == `LOAD);

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] L_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_cnt, w_cnt_nx;
    logic       r_err, w_err_nx;
`endif

    always_comb begin
        w_fsm_nx   = r_fsm;
        w_req_nx   = r_req;
        w_we_nx    = r_we;
        w_addr_nx  = r_addr;
        w_wdata_nx = r_wdata;
        w_wb_ir_nx = r_wb_ir;
        w_c1_nx    = r_c1;
        w_busy_nx  = r_busy;
        w_ir_nx    = r_ir;
`ifdef MEM_TIMEOUT_EN
        w_cnt_nx   = '0;
        w_err_nx   = r_err;
`endif
        unique case (r_fsm)
            S_IDLE: begin
                if (state == `EXEC) begin
                    if (w_mem_op) begin
                        w_req_nx   = 1'b1;
                        w_we_nx    = dw;
                        w_addr_nx  = reg_C;
                        w_wdata_nx = smdr1;
                        w_busy_nx  = 1'b1;
                        w_wb_ir_nx = 16'h0000;
                        w_ir_nx    = mem_ir;
                        w_fsm_nx   = S_WAIT;
                    end else begin
                        w_wb_ir_nx = mem_ir;
                        w_c1_nx    = reg_C;
                    end
                end
            end
            S_WAIT: begin
`ifdef MEM_TIMEOUT_EN
                w_cnt_nx = r_cnt + 8'd1;
`endif
                if (d_ack) begin
                    w_req_nx   = 1'b0;
                    w_busy_nx  = 1'b0;
                    w_wb_ir_nx = r_ir;
                    w_c1_nx    = r_we ? r_addr : d_rdata;
                    w_fsm_nx   = S_IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (r_cnt == L_LAST) begin
                    w_req_nx   = 1'b0;
                    w_busy_nx  = 1'b0;
                    w_wb_ir_nx = 16'h0000;
                    w_err_nx   = 1'b1;
                    w_fsm_nx   = S_IDLE;
                end
`endif
            end
            default: w_fsm_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fsm   <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wb_ir <= '0;
            r_c1    <= '0;
            r_busy  <= 1'b0;
            r_ir    <= '0;
        end else begin
            r_fsm   <= w_fsm_nx;
            r_req   <= w_req_nx;
            r_we    <= w_we_nx;
            r_addr  <= w_addr_nx;
            r_wdata <= w_wdata_nx;
            r_wb_ir <= w_wb_ir_nx;
            r_c1    <= w_c1_nx;
            r_busy  <= w_busy_nx;
            r_ir    <= w_ir_nx;
        end
    end

`ifdef MEM_TIMEOUT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nx;
            r_err <= w_err_nx;
        end
    end
    assign mem_err = r_err;
`else
    assign mem_err = 1'b0;
`endif

    assign d_req    = r_req;
    assign d_we     = r_we;
    assign d_addr   = r_addr;
    assign d_wdata  = r_wdata;
    assign wb_ir    = r_wb_ir;
    assign reg_C1   = r_c1;
    assign mem_busy = r_busy;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: pass-through, load/store handshakes,
// back-to-back ops, reset mid-transaction and (with MEM_TIMEOUT_EN) timeout abort.

`ifndef EXEC
`define EXEC 1'b1
`endif
`ifndef LOAD
`define LOAD 5'b10001
`endif

module tb_mem_stage;

    localparam logic [4:0] OP_ADD = 5'b00001;
    localparam logic [4:0] OP_ST  = 5'b10010;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        state = 1'b0;
    logic [15:0] mem_ir = '0;
    logic [15:0] reg_C = '0;
    logic        dw = 1'b0;
    logic [15:0] smdr1 = '0;
    logic        d_req, d_we;
    logic [15:0] d_addr, d_wdata;
    logic        d_ack = 1'b0;
    logic [15:0] d_rdata = '0;
    logic [15:0] wb_ir, reg_C1;
    logic        mem_busy, mem_err;

    int n_run = 0;
    int n_fail = 0;

    logic [15:0] ir_add, ir_ld, ir_ld2, ir_st;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .state(state),
        .mem_ir(mem_ir), .reg_C(reg_C), .dw(dw), .smdr1(smdr1),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .wb_ir(wb_ir), .reg_C1(reg_C1),
        .mem_busy(mem_busy), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        n_run++;
        if ({d_req, d_we, d_addr, d_wdata, wb_ir, reg_C1, mem_busy, mem_err} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_outputs got req=%b we=%b a=%h wd=%h ir=%h c1=%h busy=%b err=%b exp all 0",
                     d_req, d_we, d_addr, d_wdata, wb_ir, reg_C1, mem_busy, mem_err);
        end
        reset = 1'b0;
    endtask

    task automatic test_passthru();
        state = `EXEC; mem_ir = ir_add; reg_C = 16'h1234; dw = 1'b0;
        @(negedge clock);
        n_run++;
        if (wb_ir !== ir_add || reg_C1 !== 16'h1234 || d_req !== 1'b0 || mem_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL passthru got ir=%h c1=%h req=%b busy=%b exp ir=%h c1=1234 req=0 busy=0",
                     wb_ir, reg_C1, d_req, mem_busy, ir_add);
        end
        state = 1'b0;
    endtask

    task automatic test_hold();
        mem_ir = ir_ld; reg_C = 16'h0040;
        repeat (2) @(negedge clock);
        n_run++;
        if (d_req !== 1'b0 || wb_ir !== ir_add || reg_C1 !== 16'h1234) begin
            n_fail++;
            $display("FAIL hold_noexec got req=%b ir=%h c1=%h exp req=0 ir=%h c1=1234",
                     d_req, wb_ir, reg_C1, ir_add);
        end
    endtask

    task automatic test_load();
        state = `EXEC; mem_ir = ir_ld; reg_C = 16'h0040; smdr1 = 16'h1111; dw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_run++;
            if (d_req !== 1'b1 || d_we !== 1'b0 || d_addr !== 16'h0040 ||
                mem_busy !== 1'b1 || wb_ir !== 16'h0) begin
                n_fail++;
                $display("FAIL load_wait%0d got req=%b we=%b a=%h busy=%b ir=%h exp 1 0 0040 1 0000",
                         i, d_req, d_we, d_addr, mem_busy, wb_ir);
            end
            mem_ir = ir_add; reg_C = 16'hFFFF;
        end
        state = 1'b0; d_ack = 1'b1; d_rdata = 16'hBEEF;
        @(negedge clock);
        n_run++;
        if (reg_C1 !== 16'hBEEF || wb_ir !== ir_ld || mem_busy !== 1'b0 || d_req !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done got c1=%h ir=%h busy=%b req=%b exp BEEF %h 0 0",
                     reg_C1, wb_ir, mem_busy, d_req, ir_ld);
        end
        d_ack = 1'b0;
    endtask

    task automatic test_store();
        state = `EXEC; mem_ir = ir_st; reg_C = 16'h0010; smdr1 = 16'h5A5A; dw = 1'b1;
        d_ack = 1'b1; d_rdata = 16'h9999;
        @(negedge clock);
        n_run++;
        if (d_req !== 1'b1 || d_we !== 1'b1 || d_wdata !== 16'h5A5A || d_addr !== 16'h0010) begin
            n_fail++;
            $display("FAIL store_req got req=%b we=%b wd=%h a=%h exp 1 1 5A5A 0010",
                     d_req, d_we, d_wdata, d_addr);
        end
        state = 1'b0; dw = 1'b0;
        @(negedge clock);
        n_run++;
        if (d_req !== 1'b0 || reg_C1 !== 16'h0010 || wb_ir !== ir_st || mem_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL store_done got req=%b c1=%h ir=%h busy=%b exp 0 0010 %h 0",
                     d_req, reg_C1, wb_ir, mem_busy, ir_st);
        end
        d_ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        state = `EXEC; mem_ir = ir_ld; reg_C = 16'h0080; dw = 1'b0;
        @(negedge clock);
        n_run++;
        if (d_req !== 1'b1 || d_we !== 1'b0 || d_addr !== 16'h0080) begin
            n_fail++;
            $display("FAIL b2b_req1 got req=%b we=%b a=%h exp 1 0 0080", d_req, d_we, d_addr);
        end
        d_ack = 1'b1; d_rdata = 16'hCAFE;
        mem_ir = ir_ld2; dw = 1'b1; reg_C = 16'h0090; smdr1 = 16'h7777;
        @(negedge clock);
        n_run++;
        if (reg_C1 !== 16'hCAFE || wb_ir !== ir_ld || d_req !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done1 got c1=%h ir=%h req=%b exp CAFE %h 0", reg_C1, wb_ir, d_req, ir_ld);
        end
        d_ack = 1'b0;
        @(negedge clock);
        n_run++;
        if (d_req !== 1'b1 || d_we !== 1'b1 || d_addr !== 16'h0090 ||
            d_wdata !== 16'h7777 || wb_ir !== 16'h0) begin
            n_fail++;
            $display("FAIL b2b_req2_dwwins got req=%b we=%b a=%h wd=%h ir=%h exp 1 1 0090 7777 0000",
                     d_req, d_we, d_addr, d_wdata, wb_ir);
        end
        d_ack = 1'b1; d_rdata = 16'h4444; state = 1'b0; dw = 1'b0;
        @(negedge clock);
        n_run++;
        if (reg_C1 !== 16'h0090 || wb_ir !== ir_ld2 || d_req !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_done2 got c1=%h ir=%h req=%b exp 0090 %h 0", reg_C1, wb_ir, d_req, ir_ld2);
        end
    endtask

    task automatic test_ack_idle();
        d_ack = 1'b1; d_rdata = 16'hDEAD;
        repeat (2) @(negedge clock);
        n_run++;
        if (reg_C1 !== 16'h0090 || wb_ir !== ir_ld2 || d_req !== 1'b0 || mem_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_idle got c1=%h ir=%h req=%b busy=%b exp 0090 %h 0 0",
                     reg_C1, wb_ir, d_req, mem_busy, ir_ld2);
        end
        d_ack = 1'b0;
    endtask

    task automatic test_reset_wait();
        state = `EXEC; mem_ir = ir_ld; reg_C = 16'h0044; dw = 1'b0;
        @(negedge clock);
        n_run++;
        if (d_req !== 1'b1 || mem_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rstw_req got req=%b busy=%b exp 1 1", d_req, mem_busy);
        end
        reset = 1'b1; state = 1'b0;
        @(negedge clock);
        n_run++;
        if (d_req !== 1'b0 || wb_ir !== 16'h0 || mem_busy !== 1'b0 || reg_C1 !== 16'h0) begin
            n_fail++;
            $display("FAIL rstw_abort got req=%b ir=%h busy=%b c1=%h exp 0 0000 0 0000",
                     d_req, wb_ir, mem_busy, reg_C1);
        end
        reset = 1'b0; d_ack = 1'b1; d_rdata = 16'hAAAA;
        @(negedge clock);
        n_run++;
        if (d_req !== 1'b0 || wb_ir !== 16'h0 || reg_C1 !== 16'h0) begin
            n_fail++;
            $display("FAIL rstw_lateack got req=%b ir=%h c1=%h exp 0 0000 0000", d_req, wb_ir, reg_C1);
        end
        d_ack = 1'b0; state = `EXEC; mem_ir = ir_ld2; reg_C = 16'h0022;
        @(negedge clock);
        n_run++;
        if (d_req !== 1'b1 || d_addr !== 16'h0022 || d_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_newreq got req=%b a=%h we=%b exp 1 0022 0", d_req, d_addr, d_we);
        end
        state = 1'b0; d_ack = 1'b1; d_rdata = 16'h1357;
        @(negedge clock);
        n_run++;
        if (reg_C1 !== 16'h1357 || wb_ir !== ir_ld2 || mem_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstw_newdone got c1=%h ir=%h busy=%b exp 1357 %h 0", reg_C1, wb_ir, mem_busy, ir_ld2);
        end
        d_ack = 1'b0;
    endtask

    task automatic test_timeout();
`ifdef MEM_TIMEOUT_EN
        state = `EXEC; mem_ir = ir_ld; reg_C = 16'h0066; dw = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            state = 1'b0;
            n_run++;
            if (d_req !== 1'b1 || mem_err !== 1'b0) begin
                n_fail++;
                $display("FAIL to_wait%0d got req=%b err=%b exp 1 0", i, d_req, mem_err);
            end
        end
        @(negedge clock);
        n_run++;
        if (d_req !== 1'b0 || mem_err !== 1'b1 || wb_ir !== 16'h0 || mem_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL to_abort got req=%b err=%b ir=%h busy=%b exp 0 1 0000 0",
                     d_req, mem_err, wb_ir, mem_busy);
        end
        state = `EXEC; mem_ir = ir_add; reg_C = 16'h0101;
        @(negedge clock);
        state = 1'b0;
        n_run++;
        if (mem_err !== 1'b1 || wb_ir !== ir_add) begin
            n_fail++;
            $display("FAIL to_sticky got err=%b ir=%h exp 1 %h", mem_err, wb_ir, ir_add);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_run++;
        if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL to_errclr got err=%b exp 0", mem_err);
        end
`else
        state = `EXEC; mem_ir = ir_ld; reg_C = 16'h0066; dw = 1'b0;
        @(negedge clock);
        state = 1'b0;
        repeat (20) @(negedge clock);
        n_run++;
        if (d_req !== 1'b1 || mem_busy !== 1'b1 || mem_err !== 1'b0 || d_addr !== 16'h0066) begin
            n_fail++;
            $display("FAIL wait_unbounded got req=%b busy=%b err=%b a=%h exp 1 1 0 0066",
                     d_req, mem_busy, mem_err, d_addr);
        end
        d_ack = 1'b1; d_rdata = 16'h0F0F;
        @(negedge clock);
        d_ack = 1'b0;
        n_run++;
        if (reg_C1 !== 16'h0F0F || wb_ir !== ir_ld || mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_lateack got c1=%h ir=%h err=%b exp 0F0F %h 0", reg_C1, wb_ir, mem_err, ir_ld);
        end
`endif
    endtask

    initial begin
        ir_add = {OP_ADD, 11'h123};
        ir_ld  = {`LOAD, 11'h045};
        ir_ld2 = {`LOAD, 11'h3A1};
        ir_st  = {OP_ST, 11'h0F2};
        test_reset();
        test_passthru();
        test_hold();
        test_load();
        test_store();
        test_back_to_back();
        test_ack_idle();
        test_reset_wait();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
